// File: rtl/chien_search.sv
`default_nettype none
// chien_search: serial Chien search that evaluates an error-locator polynomial over GF(2^M)
// at alpha^(S+i), i = 0..N-1, one position per accepted output transfer.
module chien_search #(
    parameter int M = 4,
    parameter int T = 2,
    parameter int N = (1 << M) - 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [M*(T+1)-1:0]     sigma,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err_bit,
    output logic                   last,
    output logic                   done,
    output logic [$clog2(T+1):0]   err_count,
    output logic                   deg_match
);
    localparam int CW = $clog2(T + 1) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int S  = (1 << M) - 1 - N;
    localparam logic [CW-1:0] CMAX = '1;

    // Low-order terms of the primitive BCH field polynomial (x^M term implied).
    function automatic logic [M-1:0] poly_low(input int m);
        logic [15:0] lo;
        case (m)
            2:       lo = 16'h0003;
            3:       lo = 16'h0003;
            4:       lo = 16'h0003;
            5:       lo = 16'h0005;
            6:       lo = 16'h0003;
            7:       lo = 16'h0009;
            8:       lo = 16'h001D;
            9:       lo = 16'h0011;
            10:      lo = 16'h0009;
            11:      lo = 16'h0005;
            12:      lo = 16'h0053;
            13:      lo = 16'h001B;
            14:      lo = 16'h0443;
            15:      lo = 16'h0003;
            default: lo = 16'h100B;
        endcase
        return lo[M-1:0];
    endfunction

    localparam logic [M-1:0] POLY = poly_low(M);

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < M; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = sh[M-1] ? ((sh << 1) ^ POLY) : (sh << 1);
        end
        return acc;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e_in);
        logic [M-1:0] res;
        logic [M-1:0] base;
        int e;
        e       = e_in % ((1 << M) - 1);
        res     = '0;
        res[0]  = 1'b1;
        base    = '0;
        base[1] = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (((e >> k) & 1) != 0) res = gf_mul(res, base);
            base = gf_mul(base, base);
        end
        return res;
    endfunction

    typedef enum logic [1:0] {IDLE, INIT, RUN, FIN} state_t;
    state_t state;

    logic [M-1:0]  sig_q  [T+1];
    logic [M-1:0]  r      [T+1];
    logic [M-1:0]  w_init [T+1];
    logic [M-1:0]  w_step [T+1];
    logic [M-1:0]  w_init_sum;
    logic [M-1:0]  w_step_sum;
    logic [CW-1:0] w_deg;
    logic [CW-1:0] w_count_next;
    logic [CW-1:0] deg;
    logic [IW-1:0] i;
    logic [IW-1:0] w_i_next;

    for (genvar j = 0; j <= T; j++) begin : g_coef
        localparam logic [M-1:0] STEP_K = alpha_pow(j);
        if (S == 0) begin : g_bypass
            assign w_init[j] = sig_q[j];
        end else begin : g_scale
            localparam logic [M-1:0] INIT_K = alpha_pow(j * S);
            assign w_init[j] = gf_mul(sig_q[j], INIT_K);
        end
        assign w_step[j] = gf_mul(r[j], STEP_K);
    end

    always_comb begin
        w_init_sum = '0;
        w_step_sum = '0;
        w_deg      = '0;
        for (int j = 0; j <= T; j++) begin
            w_init_sum = w_init_sum ^ w_init[j];
            w_step_sum = w_step_sum ^ w_step[j];
            if (sig_q[j] != '0) w_deg = CW'(j);
        end
    end

    assign w_count_next = (err_bit && (err_count != CMAX)) ? err_count + 1'b1 : err_count;
    assign w_i_next     = i + 1'b1;

    // err_bit and last are registered from the next-cycle register values so they line up with r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            err_bit   <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            deg_match <= 1'b0;
            deg       <= '0;
            i         <= '0;
            for (int j = 0; j <= T; j++) begin
                r[j]     <= '0;
                sig_q[j] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= INIT;
                        busy      <= 1'b1;
                        err_count <= '0;
                        for (int j = 0; j <= T; j++) sig_q[j] <= sigma[j*M +: M];
                    end
                end
                INIT: begin
                    for (int j = 0; j <= T; j++) r[j] <= w_init[j];
                    deg       <= w_deg;
                    i         <= '0;
                    out_valid <= 1'b1;
                    err_bit   <= (w_init_sum == '0);
                    last      <= (N == 1);
                    state     <= RUN;
                end
                RUN: begin
                    if (out_ready) begin
                        err_count <= w_count_next;
                        if (last) begin
                            state     <= FIN;
                            out_valid <= 1'b0;
                            err_bit   <= 1'b0;
                            last      <= 1'b0;
                            done      <= 1'b1;
                            deg_match <= (w_count_next == deg);
                        end else begin
                            for (int j = 0; j <= T; j++) r[j] <= w_step[j];
                            i       <= w_i_next;
                            err_bit <= (w_step_sum == '0);
                            last    <= (w_i_next == IW'(N - 1));
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
